// File: rtl/conv_window_sequencer.sv
// Frame/window sequencer for the 3x3 convolution datapath: pops camera pixels, tracks the
// window position and times output-FIFO writes across the model pipeline latency.
module conv_window_sequencer #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int RD_THRESH = 5,
  parameter int MODEL_LAT = 2,
  parameter int CNT_W     = 10
) (
  input  logic             clk_w,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] in_count_i,
  input  logic             in_sof_i,
  input  logic             out_afull_i,
  output logic             in_rd_en_o,
  output logic             shift_en_o,
  output logic             win_valid_o,
  output logic             out_wr_en_o,
  output logic [10:0]      col_o,
  output logic [10:0]      row_o,
  output logic             frame_done_o,
  output logic             sof_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam int POS_W = 11;
  localparam int DRN_W = $clog2(MODEL_LAT + 1) + 1;

  localparam logic [POS_W-1:0] LAST_COL = POS_W'(IMG_W - 1);
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(IMG_H - 1);
  localparam logic [POS_W-1:0] WIN_MIN  = POS_W'(2);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(RD_THRESH);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MODEL_LAT);

  state_e state_q, state_d;

  // Position the next popped pixel will occupy; col/row outputs report the shifted one.
  logic [POS_W-1:0] nx_col_q, nx_col_d;
  logic [POS_W-1:0] nx_row_q, nx_row_d;
  logic [POS_W-1:0] col_q, col_d;
  logic [POS_W-1:0] row_q, row_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic rd_en_q, rd_en_d;
  logic shift_q, shift_d;
  logic wv_q, wv_d;
  logic done_q, done_d;
  logic sof_err_q, sof_err_d;
  logic busy_q, busy_d;

  logic [MODEL_LAT-1:0] vpipe_q, vpipe_d;
  logic [MODEL_LAT:0]   vpipe_ext;

  logic             avail;
  logic             take_px;
  logic [POS_W-1:0] px_col;
  logic [POS_W-1:0] px_row;

  assign avail = (in_count_i > THRESH) && !out_afull_i;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    nx_col_d    = nx_col_q;
    nx_row_d    = nx_row_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_cnt_d = drain_cnt_q;
    rd_en_d     = 1'b0;
    shift_d     = 1'b0;
    wv_d        = 1'b0;
    done_d      = 1'b0;
    sof_err_d   = 1'b0;
    take_px     = 1'b0;
    px_col      = nx_col_q;
    px_row      = nx_row_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_WAIT_SOF;
      end

      S_WAIT_SOF: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (avail) begin
          // Non-SOF heads are popped and dropped until a frame start shows up.
          rd_en_d = 1'b1;
          if (in_sof_i) begin
            take_px = 1'b1;
            px_col  = '0;
            px_row  = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (avail) begin
          rd_en_d = 1'b1;
          take_px = 1'b1;
          if (in_sof_i) begin
            sof_err_d = 1'b1;
            px_col    = '0;
            px_row    = '0;
          end
        end
      end

      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRN_W'(1);
        if (drain_cnt_q == DRN_LAST) begin
          done_d  = 1'b1;
          state_d = enable_i ? S_WAIT_SOF : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (take_px) begin
      shift_d = 1'b1;
      col_d   = px_col;
      row_d   = px_row;
      wv_d    = (px_col >= WIN_MIN) && (px_row >= WIN_MIN);
      if (px_col == LAST_COL) begin
        nx_col_d = '0;
        if (px_row == LAST_ROW) begin
          nx_row_d    = '0;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else begin
          nx_row_d = px_row + POS_W'(1);
        end
      end else begin
        nx_col_d = px_col + POS_W'(1);
        nx_row_d = px_row;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Valid pipe tracks the model latency; each stage carries one cycle, so gaps never merge.
  assign vpipe_ext = {vpipe_q, wv_q};
  assign vpipe_d   = vpipe_ext[MODEL_LAT-1:0];

  // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
  // NOTE: the valid pipe is reset with the FSM so an async reset discards in-flight writes.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nx_col_q    <= '0;
      nx_row_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      shift_q     <= 1'b0;
      wv_q        <= 1'b0;
      done_q      <= 1'b0;
      sof_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      vpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      nx_col_q    <= nx_col_d;
      nx_row_q    <= nx_row_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_cnt_q <= drain_cnt_d;
      rd_en_q     <= rd_en_d;
      shift_q     <= shift_d;
      wv_q        <= wv_d;
      done_q      <= done_d;
      sof_err_q   <= sof_err_d;
      busy_q      <= busy_d;
      vpipe_q     <= vpipe_d;
    end
  end

  assign in_rd_en_o   = rd_en_q;
  assign shift_en_o   = shift_q;
  assign win_valid_o  = wv_q;
  assign out_wr_en_o  = vpipe_q[MODEL_LAT-1];
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign frame_done_o = done_q;
  assign sof_err_o    = sof_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: a pixel-stream FIFO model plus a
// frame-level reference that predicts shifts, windows, writes and frame completion.
module tb_conv_window_sequencer;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int LAT = 2;
  localparam int THR = 5;
  localparam int CW  = 10;
  localparam int N   = W * H;

  logic          clk_w = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [CW-1:0] in_count_i = '0;
  logic          in_sof_i = 1'b0;
  logic          out_afull_i = 1'b0;
  logic          in_rd_en_o, shift_en_o, win_valid_o, out_wr_en_o;
  logic [10:0]   col_o, row_o;
  logic          frame_done_o, sof_err_o, busy_o;

  conv_window_sequencer #(
    .IMG_W(W), .IMG_H(H), .RD_THRESH(THR), .MODEL_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk_w(clk_w), .rst_n(rst_n), .enable_i(enable_i), .in_count_i(in_count_i),
    .in_sof_i(in_sof_i), .out_afull_i(out_afull_i), .in_rd_en_o(in_rd_en_o),
    .shift_en_o(shift_en_o), .win_valid_o(win_valid_o), .out_wr_en_o(out_wr_en_o),
    .col_o(col_o), .row_o(row_o), .frame_done_o(frame_done_o), .sof_err_o(sof_err_o),
    .busy_o(busy_o)
  );

  always #5 clk_w = ~clk_w;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Camera FIFO contents (SOF flag per pixel) and an optional forced fill level.
  bit fifo_q[$];
  int ovr_count = -1;

  // Reference model state.
  bit in_frame = 1'b0;
  int pos = 0;
  int drain_until = 0;
  int wr_due[$];
  int done_due[$];

  int n_shift, n_wv, n_wr, n_done, n_err, n_disc;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    int lvl;
    lvl = fifo_q.size();
    if (ovr_count >= 0 && lvl > 10) lvl = ovr_count;
    if (lvl > 1023) lvl = 1023;
    in_count_i = CW'(lvl);
    in_sof_i   = (fifo_q.size() > 0) ? fifo_q[0] : 1'b0;
  endtask

  task automatic clear_counts();
    n_shift = 0; n_wv = 0; n_wr = 0; n_done = 0; n_err = 0; n_disc = 0;
  endtask

  task automatic push_px(input int n, input bit first_sof);
    for (int i = 0; i < n; i++) fifo_q.push_back(first_sof && (i == 0));
  endtask

  function automatic int valid_in_prefix(input int k);
    int v = 0;
    for (int i = 0; i < k; i++)
      if ((i % W) >= 2 && (i / W) >= 2) v++;
    return v;
  endfunction

  task automatic monitor(input bit av, input bit en);
    bit e_shift = 0, e_wv = 0, e_err = 0, e_wr = 0, e_done = 0, sof = 0;
    int c = 0, r = 0;
    if (in_rd_en_o) begin
      check("pop_avail", int'(av), 1);
      check("pop_in_drain", int'(cyc >= drain_until), 1);
      if (!in_frame) check("pop_enable", int'(en), 1);
      check("fifo_nonempty", int'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) sof = fifo_q.pop_front();
      if (!in_frame) begin
        if (sof) begin
          e_shift = 1; in_frame = 1; pos = 1;
        end else begin
          n_disc++;
        end
      end else begin
        e_shift = 1;
        if (sof) begin
          e_err = 1; pos = 1;
        end else begin
          c = pos % W; r = pos / W; pos++;
          if (pos == N) begin
            in_frame = 0;
            drain_until = cyc + LAT + 2;
            done_due.push_back(cyc + LAT + 1);
          end
        end
      end
      e_wv = e_shift && c >= 2 && r >= 2;
      if (e_wv) wr_due.push_back(cyc + LAT);
    end
    if (wr_due.size() > 0 && wr_due[0] == cyc) begin
      e_wr = 1; void'(wr_due.pop_front());
    end
    if (done_due.size() > 0 && done_due[0] == cyc) begin
      e_done = 1; void'(done_due.pop_front());
    end
    check("shift_en", int'(shift_en_o), int'(e_shift));
    check("win_valid", int'(win_valid_o), int'(e_wv));
    check("sof_err", int'(sof_err_o), int'(e_err));
    check("out_wr_en", int'(out_wr_en_o), int'(e_wr));
    check("frame_done", int'(frame_done_o), int'(e_done));
    if (e_shift) begin
      check("col", int'(col_o), c);
      check("row", int'(row_o), r);
      check("busy_run", int'(busy_o), 1);
    end
    n_shift += int'(shift_en_o);
    n_wv    += int'(win_valid_o);
    n_wr    += int'(out_wr_en_o);
    n_done  += int'(frame_done_o);
    n_err   += int'(sof_err_o);
  endtask

  task automatic step();
    bit av, en;
    av = (int'(in_count_i) > THR) && !out_afull_i;
    en = enable_i;
    @(posedge clk_w);
    #1;
    cyc++;
    monitor(av, en);
    drive();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < budget) begin
      step();
      k++;
    end
    check(tag, int'(n_done > start), 1);
  endtask

  task automatic wait_pos(input int target, input int budget, input string tag);
    int k = 0;
    while (!(in_frame && pos >= target) && k < budget) begin
      step();
      k++;
    end
    check(tag, int'(in_frame && pos >= target), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable_i = 1'b0;
    out_afull_i = 1'b0;
    ovr_count = -1;
    fifo_q.delete();
    wr_due.delete();
    done_due.delete();
    in_frame = 0; pos = 0; drain_until = 0;
    drive();
    repeat (2) @(posedge clk_w);
    #1;
    check("rst_rd_en", int'(in_rd_en_o), 0);
    check("rst_shift", int'(shift_en_o), 0);
    check("rst_wr_en", int'(out_wr_en_o), 0);
    check("rst_col", int'(col_o), 0);
    check("rst_row", int'(row_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(frame_done_o), 0);
    rst_n = 1'b1;
    clear_counts();
  endtask

  initial begin
    int frames, aborts, exp_shift, exp_wv, g, k;

    // Basic frame preceded by three non-SOF pixels.
    do_reset();
    enable_i = 1'b1;
    push_px(3, 0);
    push_px(N, 1);
    push_px(8, 0);
    drive();
    run_until_done(300, "a_done_timeout");
    check("a_discards", n_disc, 3);
    check("a_shifts", n_shift, N);
    check("a_win_valid", n_wv, 12);
    check("a_wr_en", n_wr, 12);
    check("a_frame_done", n_done, 1);
    check("a_sof_err", n_err, 0);

    // Output back-pressure mid-row with window writes still in flight.
    clear_counts();
    push_px(N, 1);
    push_px(8, 0);
    drive();
    wait_pos(20, 300, "b_reach_timeout");
    out_afull_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("b_afull_no_pop", int'(in_rd_en_o), 0);
      check("b_hold_col", int'(col_o), (pos - 1) % W);
      check("b_hold_row", int'(row_o), (pos - 1) / W);
    end
    out_afull_i = 1'b0;
    run_until_done(300, "b_done_timeout");
    check("b_win_valid", n_wv, 12);
    check("b_wr_en", n_wr, 12);
    check("b_frame_done", n_done, 1);

    // Read threshold boundary: count equal to threshold stalls, one above pops.
    clear_counts();
    push_px(N, 1);
    push_px(8, 0);
    drive();
    wait_pos(6, 300, "c_reach_timeout");
    ovr_count = THR;
    drive();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_thresh_no_pop", int'(in_rd_en_o), 0);
    end
    ovr_count = THR + 1;
    drive();
    step();
    check("c_thresh_pop", int'(in_rd_en_o), 1);
    ovr_count = -1;
    drive();
    run_until_done(300, "c_done_timeout");
    check("c_shifts", n_shift, N);

    // SOF arriving at row 2, column 5 restarts the frame.
    clear_counts();
    push_px(2 * W + 5, 1);
    push_px(N, 1);
    push_px(8, 0);
    drive();
    run_until_done(400, "d_done_timeout");
    repeat (4) step();
    check("d_sof_err", n_err, 1);
    check("d_frame_done", n_done, 1);
    check("d_shifts", n_shift, 2 * W + 5 + N);
    check("d_win_valid", n_wv, 3 + 12);
    check("d_wr_en", n_wr, 3 + 12);

    // Enable dropped mid-frame: frame completes, then the block idles.
    clear_counts();
    push_px(N, 1);
    push_px(8, 0);
    drive();
    wait_pos(10, 300, "e_reach_timeout");
    enable_i = 1'b0;
    run_until_done(300, "e_done_timeout");
    check("e_shifts", n_shift, N);
    for (int i = 0; i < 6; i++) step();
    check("e_busy_idle", int'(busy_o), 0);
    check("e_no_pop_idle", int'(in_rd_en_o), 0);
    check("e_fifo_untouched", int'(fifo_q.size() > THR), 1);

    // Randomized frames, aborts, back-pressure and fill-level dips.
    clear_counts();
    enable_i = 1'b1;
    frames = 6; aborts = 0; exp_shift = 0; exp_wv = 0;
    for (int f = 0; f < frames; f++) begin
      g = $urandom_range(0, 3);
      push_px(g, 0);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, N - 1);
        push_px(k, 1);
        aborts++;
        exp_shift += k;
        exp_wv += valid_in_prefix(k);
      end
      push_px(N, 1);
      exp_shift += N;
      exp_wv += 12;
    end
    push_px(8, 0);
    drive();
    for (int i = 0; i < 6000; i++) begin
      if (i > 20 && fifo_q.size() <= THR && !in_frame && wr_due.size() == 0 &&
          done_due.size() == 0) break;
      out_afull_i = ($urandom_range(0, 4) == 0);
      ovr_count = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 8)) : -1;
      drive();
      step();
    end
    out_afull_i = 1'b0;
    ovr_count = -1;
    drive();
    check("r_frame_done", n_done, frames);
    check("r_sof_err", n_err, aborts);
    check("r_shifts", n_shift, exp_shift);
    check("r_win_valid", n_wv, exp_wv);
    check("r_wr_en", n_wr, exp_wv);

    // Asynchronous reset in the middle of a frame, then recovery.
    clear_counts();
    push_px(N, 1);
    push_px(8, 0);
    drive();
    wait_pos(15, 300, "g_reach_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check("g_async_rd_en", int'(in_rd_en_o), 0);
    check("g_async_shift", int'(shift_en_o), 0);
    check("g_async_col", int'(col_o), 0);
    check("g_async_row", int'(row_o), 0);
    check("g_async_busy", int'(busy_o), 0);
    check("g_async_wr_en", int'(out_wr_en_o), 0);
    do_reset();
    enable_i = 1'b1;
    push_px(N, 1);
    push_px(8, 0);
    drive();
    run_until_done(300, "g_recover_timeout");
    check("g_recover_shifts", n_shift, N);
    check("g_recover_wr_en", n_wr, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
